// File: rtl/ahb_bus_ctrl_pkg.sv
// Shared AHB-lite definitions for the bus controller: transfer encodings,
// response codes, slot indices, FSM state encoding and the debug snapshot.
package ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  localparam logic [1:0] SLOT_ROM  = 2'd0;
  localparam logic [1:0] SLOT_RAM  = 2'd1;
  localparam logic [1:0] SLOT_UART = 2'd2;
  localparam logic [1:0] SLOT_SIM  = 2'd3;

  localparam int unsigned NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_t;

  typedef struct packed {
    ahb_state_t state;
    logic [1:0] slot;
    logic [7:0] cnt;
    logic       write;
  } ahb_dbg_t;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_transfer(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_bus_ctrl_if.sv
// Bus bundle between the CPU, the four slave slots and the interconnect controller.
// Transfer handshake: an address phase is taken when M_TRANS_I[1] and M_READY_O are both
// high in one cycle; its data phase completes in the first later cycle with M_READY_O high.
interface ahb_bus_ctrl_if;
  import ahb_defs::*;

  logic [31:0]  M_ADR_I;
  logic [1:0]   M_TRANS_I;
  logic         M_WRITE_I;
  logic [31:0]  M_DATA_O;
  logic         M_READY_O;
  logic         M_RESP_O;
  logic [3:0]   S_SEL_O;
  logic [127:0] S_DATA_I;
  logic [3:0]   S_READY_I;
  logic         ERR_VALID_O;
  logic [31:0]  ERR_ADR_O;
  logic         ERR_TO_O;
  logic         ERR_CLR_I;
  ahb_dbg_t     DBG_O;

  // slave: the controller, which answers the CPU; master: the CPU and slot side.
  modport slave (
    input  M_ADR_I, M_TRANS_I, M_WRITE_I, S_DATA_I, S_READY_I, ERR_CLR_I,
    output M_DATA_O, M_READY_O, M_RESP_O, S_SEL_O,
    output ERR_VALID_O, ERR_ADR_O, ERR_TO_O, DBG_O
  );

  modport master (
    output M_ADR_I, M_TRANS_I, M_WRITE_I, S_DATA_I, S_READY_I, ERR_CLR_I,
    input  M_DATA_O, M_READY_O, M_RESP_O, S_SEL_O,
    input  ERR_VALID_O, ERR_ADR_O, ERR_TO_O, DBG_O
  );

endinterface

// File: rtl/ahb_bus_ctrl_addr_decode.sv
// Combinational address decoder: ADR[31:16] -> one-hot slot select, hit flag and slot index.
module ahb_addr_decode #(
  parameter logic [15:0] BASE0 = 16'h0000,
  parameter logic [15:0] BASE1 = 16'h0001,
  parameter logic [15:0] BASE2 = 16'h4000,
  parameter logic [15:0] BASE3 = 16'h4001
) (
  input  logic [15:0] i_adr_hi,
  output logic [3:0]  o_sel,
  output logic        o_hit,
  output logic [1:0]  o_slot
);
  import ahb_defs::*;

  always_comb begin
    o_sel  = '0;
    o_slot = SLOT_ROM;
    o_sel[0] = (i_adr_hi == BASE0);
    o_sel[1] = (i_adr_hi == BASE1);
    o_sel[2] = (i_adr_hi == BASE2);
    o_sel[3] = (i_adr_hi == BASE3);
    o_hit  = |o_sel;
    // Lowest slot wins if two bases were ever configured identically.
    if (o_sel[3]) o_slot = SLOT_SIM;
    if (o_sel[2]) o_slot = SLOT_UART;
    if (o_sel[1]) o_slot = SLOT_RAM;
    if (o_sel[0]) o_slot = SLOT_ROM;
  end

endmodule

// File: rtl/ahb_bus_ctrl.sv
// AHB-lite single-master interconnect: address decode, data-phase tracking, read/ready
// mux, two-cycle ERROR response for unmapped or timed-out transfers, first-error log.
module ahb_bus_ctrl
  import ahb_defs::*;
#(
  parameter logic [15:0] BASE0   = 16'h0000,
  parameter logic [15:0] BASE1   = 16'h0001,
  parameter logic [15:0] BASE2   = 16'h4000,
  parameter logic [15:0] BASE3   = 16'h4001,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  ahb_bus_ctrl_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  ahb_state_t  r_state;
  logic [1:0]  r_slot;
  logic [31:0] r_adr;
  logic [7:0]  r_cnt;
  logic        r_write;
  logic        r_err_valid;
  logic [31:0] r_err_adr;
  logic        r_err_to;

  ahb_state_t  w_next;
  logic [3:0]  w_dec_sel;
  logic        w_dec_hit;
  logic [1:0]  w_dec_slot;
  logic        w_ready;
  logic        w_resp;
  logic [31:0] w_data;
  logic        w_accept;
  logic        w_slot_ready;
  logic [31:0] w_slot_data;
  logic [7:0]  w_cnt_inc;
  logic [7:0]  w_cnt_next;
  logic        w_err_entry;
  logic        w_err_to;
  logic [31:0] w_err_adr;

  ahb_addr_decode #(
    .BASE0 (BASE0),
    .BASE1 (BASE1),
    .BASE2 (BASE2),
    .BASE3 (BASE3)
  ) u_decode (
    .i_adr_hi (bus.M_ADR_I[31:16]),
    .o_sel    (w_dec_sel),
    .o_hit    (w_dec_hit),
    .o_slot   (w_dec_slot)
  );

  // Only the registered slot is looked at; other slots' ready/data never leak through.
  assign w_slot_ready = bus.S_READY_I[r_slot];
  assign w_slot_data  = bus.S_DATA_I[{r_slot, 5'd0} +: 32];

  always_comb begin
    w_ready = 1'b1;
    w_resp  = RESP_OKAY;
    w_data  = '0;
    case (r_state)
      ST_DATA: begin
        w_ready = w_slot_ready;
        w_data  = w_slot_data;
      end
      ST_ERR1: begin
        w_ready = 1'b0;
        w_resp  = RESP_ERROR;
      end
      ST_ERR2: begin
        w_resp  = RESP_ERROR;
      end
      default: ;
    endcase
  end

  assign w_accept  = is_transfer(bus.M_TRANS_I) & w_ready;
  assign w_cnt_inc = 8'(r_cnt + 8'd1);

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_err_entry = 1'b0;
    w_err_to    = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_next = ST_IDLE;
        if (w_accept) begin
          w_next      = w_dec_hit ? ST_DATA : ST_ERR1;
          w_err_entry = ~w_dec_hit;
          w_cnt_next  = '0;
        end
      end
      ST_DATA: begin
        if (w_slot_ready) begin
          w_next = ST_IDLE;
          if (w_accept) begin
            w_next      = w_dec_hit ? ST_DATA : ST_ERR1;
            w_err_entry = ~w_dec_hit;
            w_cnt_next  = '0;
          end
        end else if (w_cnt_inc == TO_LAST) begin
          // The ERR1 cycle is the last of the TIMEOUT wait cycles the CPU sees.
          w_next      = ST_ERR1;
          w_err_entry = 1'b1;
          w_err_to    = 1'b1;
          w_cnt_next  = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ST_ERR1: w_next = ST_ERR2;
      default: w_next = ST_IDLE;
    endcase
  end

  // A timeout blames the stalled data phase; an unmapped miss blames the address being taken.
  assign w_err_adr = w_err_to ? r_adr : bus.M_ADR_I;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= ST_IDLE;
      r_slot      <= SLOT_ROM;
      r_adr       <= '0;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_adr   <= '0;
      r_err_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_slot  <= w_dec_slot;
        r_adr   <= bus.M_ADR_I;
        r_write <= bus.M_WRITE_I;
      end
      // A clear in the same cycle as a new error loses to the new error.
      if (w_err_entry && (!r_err_valid || bus.ERR_CLR_I)) begin
        r_err_valid <= 1'b1;
        r_err_adr   <= w_err_adr;
        r_err_to    <= w_err_to;
      end else if (bus.ERR_CLR_I) begin
        r_err_valid <= 1'b0;
        r_err_to    <= 1'b0;
      end
    end
  end

  assign bus.M_READY_O   = w_ready;
  assign bus.M_RESP_O    = w_resp;
  assign bus.M_DATA_O    = w_data;
  assign bus.S_SEL_O     = w_dec_sel & {4{w_accept}};
  assign bus.ERR_VALID_O = r_err_valid;
  assign bus.ERR_ADR_O   = r_err_adr;
  assign bus.ERR_TO_O    = r_err_to;
  assign bus.DBG_O       = '{state: r_state, slot: r_slot, cnt: r_cnt, write: r_write};

endmodule

// File: tb/tb_ahb_bus_ctrl.sv
// Table-driven bench for ahb_bus_ctrl: one record per clock cycle with the inputs to drive
// and the outputs expected in that cycle, plus timeout and reset sequences.
module tb_ahb_bus_ctrl;
  import ahb_defs::*;

  localparam logic [31:0] D_ROM  = 32'hCAFE_F00D;
  localparam logic [31:0] D_RAM  = 32'h1111_2222;
  localparam logic [31:0] D_UART = 32'h3333_4444;
  localparam logic [31:0] D_SIM  = 32'h5555_6666;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef struct {
    logic        rst;
    logic [31:0] adr;
    logic [1:0]  trans;
    logic        wr;
    logic [3:0]  s_ready;
    logic        clr;
    logic        e_ready;
    logic        e_resp;
    logic [31:0] e_data;
    logic [3:0]  e_sel;
    logic        e_ev;
    logic        e_eto;
    logic [31:0] e_eadr;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ahb_bus_ctrl_if bus ();

  ahb_bus_ctrl #(
    .BASE0   (16'h0000),
    .BASE1   (16'h0001),
    .BASE2   (16'h4000),
    .BASE3   (16'h4001),
    .TIMEOUT (16)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst_v, input logic [31:0] adr, input logic [1:0] trans, input logic wr,
    input logic [3:0] s_ready, input logic clr,
    input logic e_ready, input logic e_resp, input logic [31:0] e_data, input logic [3:0] e_sel,
    input logic e_ev, input logic e_eto, input logic [31:0] e_eadr);
    vec_t v;
    v.rst = rst_v; v.adr = adr; v.trans = trans; v.wr = wr; v.s_ready = s_ready; v.clr = clr;
    v.e_ready = e_ready; v.e_resp = e_resp; v.e_data = e_data; v.e_sel = e_sel;
    v.e_ev = e_ev; v.e_eto = e_eto; v.e_eadr = e_eadr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then compare just after.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.M_ADR_I   = v.adr;
    bus.M_TRANS_I = v.trans;
    bus.M_WRITE_I = v.wr;
    bus.S_READY_I = v.s_ready;
    bus.ERR_CLR_I = v.clr;
    #1;
    chk({tag, ".ready"},     32'(bus.M_READY_O),   32'(v.e_ready));
    chk({tag, ".resp"},      32'(bus.M_RESP_O),    32'(v.e_resp));
    chk({tag, ".data"},      bus.M_DATA_O,         v.e_data);
    chk({tag, ".sel"},       32'(bus.S_SEL_O),     32'(v.e_sel));
    chk({tag, ".err_valid"}, 32'(bus.ERR_VALID_O), 32'(v.e_ev));
    chk({tag, ".err_to"},    32'(bus.ERR_TO_O),    32'(v.e_eto));
    chk({tag, ".err_adr"},   bus.ERR_ADR_O,        v.e_eadr);
  endtask

  vec_t tbl[20];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst           = 1'b1;
    bus.M_ADR_I   = '0;
    bus.M_TRANS_I = HTRANS_IDLE;
    bus.M_WRITE_I = 1'b0;
    bus.S_READY_I = 4'hF;
    bus.ERR_CLR_I = 1'b0;
    bus.S_DATA_I  = {D_SIM, D_UART, D_RAM, D_ROM};

    // BUSY is not a transfer; rom read data appears one cycle after its address.
    tbl[0]  = mk(0, 32'h0000_0010, HTRANS_BUSY,   RD, 4'hF, 0, 1, 0, 32'h0,  4'b0000, 0, 0, 32'h0);
    tbl[1]  = mk(0, 32'h0000_0010, HTRANS_NONSEQ, RD, 4'hF, 0, 1, 0, 32'h0,  4'b0001, 0, 0, 32'h0);
    tbl[2]  = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 0, 1, 0, D_ROM,  4'b0000, 0, 0, 32'h0);
    // Back-to-back ram write then read, no stall.
    tbl[3]  = mk(0, 32'h0001_0004, HTRANS_NONSEQ, WR, 4'hF, 0, 1, 0, 32'h0,  4'b0010, 0, 0, 32'h0);
    tbl[4]  = mk(0, 32'h0001_0008, HTRANS_SEQ,    RD, 4'hF, 0, 1, 0, D_RAM,  4'b0010, 0, 0, 32'h0);
    tbl[5]  = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 0, 1, 0, D_RAM,  4'b0000, 0, 0, 32'h0);
    // Unmapped read: ERR1 then ERR2, address logged.
    tbl[6]  = mk(0, 32'h2000_0000, HTRANS_NONSEQ, RD, 4'hF, 0, 1, 0, 32'h0,  4'b0000, 0, 0, 32'h0);
    tbl[7]  = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 0, 0, 1, 32'h0,  4'b0000, 1, 0, 32'h2000_0000);
    tbl[8]  = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 0, 1, 1, 32'h0,  4'b0000, 1, 0, 32'h2000_0000);
    // sim stalls while ram shows ready; then ram stalls while sim shows ready.
    tbl[9]  = mk(0, 32'h4001_0000, HTRANS_NONSEQ, RD, 4'hF, 0, 1, 0, 32'h0,  4'b1000, 1, 0, 32'h2000_0000);
    tbl[10] = mk(0, 32'h0001_0000, HTRANS_NONSEQ, RD, 4'h7, 0, 0, 0, D_SIM,  4'b0000, 1, 0, 32'h2000_0000);
    tbl[11] = mk(0, 32'h0001_0000, HTRANS_NONSEQ, RD, 4'h8, 0, 1, 0, D_SIM,  4'b0010, 1, 0, 32'h2000_0000);
    tbl[12] = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hD, 0, 0, 0, D_RAM,  4'b0000, 1, 0, 32'h2000_0000);
    tbl[13] = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'h2, 0, 1, 0, D_RAM,  4'b0000, 1, 0, 32'h2000_0000);
    // Second error keeps the first; a clear coincident with a new error logs the new one.
    tbl[14] = mk(0, 32'h3000_0000, HTRANS_NONSEQ, RD, 4'hF, 0, 1, 0, 32'h0,  4'b0000, 1, 0, 32'h2000_0000);
    tbl[15] = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 0, 0, 1, 32'h0,  4'b0000, 1, 0, 32'h2000_0000);
    tbl[16] = mk(0, 32'h3000_0004, HTRANS_NONSEQ, RD, 4'hF, 1, 1, 1, 32'h0,  4'b0000, 1, 0, 32'h2000_0000);
    tbl[17] = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 0, 0, 1, 32'h0,  4'b0000, 1, 0, 32'h3000_0004);
    tbl[18] = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 1, 1, 1, 32'h0,  4'b0000, 1, 0, 32'h3000_0004);
    tbl[19] = mk(0, 32'h0,         HTRANS_IDLE,   RD, 4'hF, 0, 1, 0, 32'h0,  4'b0000, 0, 0, 32'h3000_0004);

    repeat (3) @(posedge clk);

    for (int i = 0; i < 20; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // uart write stalls: 15 low-ready data cycles, then ERR1/ERR2 with a timeout log.
    apply("to_addr", mk(0, 32'h4000_0000, HTRANS_NONSEQ, WR, 4'hB, 0, 1, 0, 32'h0, 4'b0100, 0, 0, 32'h3000_0004));
    for (int k = 0; k < 15; k++)
      apply($sformatf("to_wait%0d", k),
            mk(0, 32'h0, HTRANS_IDLE, RD, 4'hB, 0, 0, 0, D_UART, 4'b0000, 0, 0, 32'h3000_0004));
    apply("to_err1", mk(0, 32'h0, HTRANS_IDLE, RD, 4'hB, 0, 0, 1, 32'h0, 4'b0000, 1, 1, 32'h4000_0000));
    apply("to_err2", mk(0, 32'h0, HTRANS_IDLE, RD, 4'hB, 0, 1, 1, 32'h0, 4'b0000, 1, 1, 32'h4000_0000));
    apply("to_late", mk(0, 32'h0, HTRANS_IDLE, RD, 4'hF, 0, 1, 0, 32'h0, 4'b0000, 1, 1, 32'h4000_0000));

    // Reset during a stalled ram data phase; a stray ram ready afterwards is ignored.
    apply("rs_addr", mk(0, 32'h0001_0000, HTRANS_NONSEQ, RD, 4'hD, 0, 1, 0, 32'h0, 4'b0010, 1, 1, 32'h4000_0000));
    apply("rs_wait", mk(0, 32'h0, HTRANS_IDLE, RD, 4'hD, 0, 0, 0, D_RAM, 4'b0000, 1, 1, 32'h4000_0000));
    apply("rs_rst",  mk(1, 32'h0, HTRANS_IDLE, RD, 4'hD, 0, 0, 0, D_RAM, 4'b0000, 1, 1, 32'h4000_0000));
    apply("rs_post", mk(0, 32'h0, HTRANS_IDLE, RD, 4'hD, 0, 1, 0, 32'h0, 4'b0000, 0, 0, 32'h0));
    apply("rs_stray", mk(0, 32'h0, HTRANS_IDLE, RD, 4'h2, 0, 1, 0, 32'h0, 4'b0000, 0, 0, 32'h0));
    apply("rs_idle", mk(0, 32'h0, HTRANS_IDLE, RD, 4'hF, 0, 1, 0, 32'h0, 4'b0000, 0, 0, 32'h0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
